// File: rtl/aes_dec_ingress.sv
// aes_dec_ingress: ingress FIFO, K10 key manager and in-flight tracker
// feeding the round-10 stage of the pipelined AES-128 decryptor.
// Optional feature macro: DEC_INGRESS_STATS_EN adds the blk_count issue counter.
module aes_dec_ingress #(
    parameter int BLOCK_LENGTH = 128,
    parameter int FIFO_DEPTH   = 4,
    parameter int PIPE_DEPTH   = 10
`ifdef DEC_INGRESS_STATS_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLOCK_LENGTH-1:0] in_data,
    input  logic                    key_load,
    input  logic [BLOCK_LENGTH-1:0] key_in,
    output logic                    key_busy,
    output logic [BLOCK_LENGTH-1:0] r10_in,
    output logic [BLOCK_LENGTH-1:0] r10_key,
    output logic                    r10_en,
    output logic                    out_valid
`ifdef DEC_INGRESS_STATS_EN
    ,
    output logic [CNT_W-1:0]        blk_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        NOKEY,
        RUN,
        DRAIN
    } state_t;

    state_t                  state;
    logic [BLOCK_LENGTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [BLOCK_LENGTH-1:0] pend_key;
    logic [PIPE_DEPTH-1:0]   tracker;
    logic                    push;
    logic                    pop;
    logic                    idle;

    assign in_ready  = (state == RUN) && (count < DEPTH_C);
    assign push      = in_valid && in_ready;
    assign pop       = (count != '0);
    // Nothing buffered, nothing at the round-10 input, nothing in the pipe.
    assign idle      = (count == '0) && !r10_en && (tracker == '0);
    assign key_busy  = (state == DRAIN);
    assign out_valid = tracker[PIPE_DEPTH-1];

    // FIFO storage write; contents need no reset, count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue the FIFO head to round 10 every cycle the FIFO holds data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r10_in <= '0;
            r10_en <= 1'b0;
        end else begin
            r10_en <= pop;
            if (pop) begin
                r10_in <= mem[rd_ptr];
            end
        end
    end

    // Shift issued-block markers down the pipe to time out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tracker <= '0;
        end else begin
            tracker <= {tracker[PIPE_DEPTH-2:0], r10_en};
        end
    end

    // Key FSM: swap K10 only when no block can observe the change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NOKEY;
            r10_key  <= '0;
            pend_key <= '0;
        end else begin
            unique case (state)
                NOKEY: begin
                    if (key_load) begin
                        r10_key <= key_in;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (key_load) begin
                        if (idle && !push) begin
                            r10_key <= key_in;
                        end else begin
                            pend_key <= key_in;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (key_load) begin
                        pend_key <= key_in;
                    end
                    if (idle) begin
                        r10_key <= key_load ? key_in : pend_key;
                        state   <= RUN;
                    end
                end
                default: begin
                    state <= NOKEY;
                end
            endcase
        end
    end

`ifdef DEC_INGRESS_STATS_EN
    // Count issued blocks; wraps at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count <= '0;
        end else if (pop) begin
            blk_count <= blk_count + 1'b1;
        end
    end
`endif

endmodule
